// File: rtl/tlb_array_if.sv
// Search, write and read buses of the fully-associative TLB array.
// The master side issues searches, writes and reads; the slave side holds the entries.
interface tlb_array_if;
  logic        s0_req;
  logic [18:0] s0_vpn2;
  logic        s0_odd_page;
  logic [7:0]  s0_asid;
  logic        s0_rvalid;
  logic        s0_found;
  logic [3:0]  s0_index;
  logic [19:0] s0_pfn;
  logic [2:0]  s0_c;
  logic        s0_d;
  logic        s0_v;

  logic        s1_req;
  logic [18:0] s1_vpn2;
  logic        s1_odd_page;
  logic [7:0]  s1_asid;
  logic        s1_rvalid;
  logic        s1_found;
  logic [3:0]  s1_index;
  logic [19:0] s1_pfn;
  logic [2:0]  s1_c;
  logic        s1_d;
  logic        s1_v;

  logic        we;
  logic [3:0]  w_index;
  logic [18:0] w_vpn2;
  logic [7:0]  w_asid;
  logic        w_g;
  logic [24:0] w_lo0;
  logic [24:0] w_lo1;

  logic [3:0]  r_index;
  logic [18:0] r_vpn2;
  logic [7:0]  r_asid;
  logic        r_g;
  logic [24:0] r_lo0;
  logic [24:0] r_lo1;

  modport master (
    output s0_req, s0_vpn2, s0_odd_page, s0_asid,
    input  s0_rvalid, s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
    output s1_req, s1_vpn2, s1_odd_page, s1_asid,
    input  s1_rvalid, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
    output we, w_index, w_vpn2, w_asid, w_g, w_lo0, w_lo1,
    output r_index,
    input  r_vpn2, r_asid, r_g, r_lo0, r_lo1
  );

  modport slave (
    input  s0_req, s0_vpn2, s0_odd_page, s0_asid,
    output s0_rvalid, s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
    input  s1_req, s1_vpn2, s1_odd_page, s1_asid,
    output s1_rvalid, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
    input  we, w_index, w_vpn2, w_asid, w_g, w_lo0, w_lo1,
    input  r_index,
    output r_vpn2, r_asid, r_g, r_lo0, r_lo1
  );
endinterface

// File: rtl/tlb_array.sv
// Fully-associative TLB storage with two registered search ports,
// one write port and one combinational read port.
module tlb_array #(
  parameter int TLBNUM = 16
) (
  input  logic clk,
  input  logic reset,
  tlb_array_if.slave bus
);

  logic [18:0] vpn2_q [TLBNUM];
  logic [7:0]  asid_q [TLBNUM];
  logic        g_q    [TLBNUM];
  logic [24:0] lo0_q  [TLBNUM];
  logic [24:0] lo1_q  [TLBNUM];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TLBNUM; i++) begin
        vpn2_q[i] <= '0;
        asid_q[i] <= '0;
        g_q[i]    <= 1'b0;
        lo0_q[i]  <= '0;
        lo1_q[i]  <= '0;
      end
    end else if (bus.we) begin
      vpn2_q[bus.w_index] <= bus.w_vpn2;
      asid_q[bus.w_index] <= bus.w_asid;
      g_q[bus.w_index]    <= bus.w_g;
      lo0_q[bus.w_index]  <= bus.w_lo0;
      lo1_q[bus.w_index]  <= bus.w_lo1;
    end
  end

  assign bus.r_vpn2 = vpn2_q[bus.r_index];
  assign bus.r_asid = asid_q[bus.r_index];
  assign bus.r_g    = g_q[bus.r_index];
  assign bus.r_lo0  = lo0_q[bus.r_index];
  assign bus.r_lo1  = lo1_q[bus.r_index];

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic        req;
    logic [18:0] vpn2;
    logic        odd;
    logic [7:0]  asid;
    logic        hit;
    logic [3:0]  hit_idx;
    logic [24:0] hit_lo;
    logic        rvalid;
    logic        found;
    logic [3:0]  index;
    logic [24:0] lo;

    assign req  = (p == 0) ? bus.s0_req      : bus.s1_req;
    assign vpn2 = (p == 0) ? bus.s0_vpn2     : bus.s1_vpn2;
    assign odd  = (p == 0) ? bus.s0_odd_page : bus.s1_odd_page;
    assign asid = (p == 0) ? bus.s0_asid     : bus.s1_asid;

    // Scanning from the top down lets the lowest matching index overwrite the rest.
    always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      hit_lo  = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
        if (vpn2_q[i] == vpn2 && (g_q[i] || asid_q[i] == asid)) begin
          hit     = 1'b1;
          hit_idx = 4'(i);
          hit_lo  = odd ? lo1_q[i] : lo0_q[i];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        rvalid <= 1'b0;
        found  <= 1'b0;
        index  <= '0;
        lo     <= '0;
      end else begin
        rvalid <= req;
        if (req) begin
          found <= hit;
          index <= hit_idx;
          lo    <= hit_lo;
        end
      end
    end
  end

  assign bus.s0_rvalid = g_port[0].rvalid;
  assign bus.s0_found  = g_port[0].found;
  assign bus.s0_index  = g_port[0].index;
  assign bus.s0_pfn    = g_port[0].lo[24:5];
  assign bus.s0_c      = g_port[0].lo[4:2];
  assign bus.s0_d      = g_port[0].lo[1];
  assign bus.s0_v      = g_port[0].lo[0];

  assign bus.s1_rvalid = g_port[1].rvalid;
  assign bus.s1_found  = g_port[1].found;
  assign bus.s1_index  = g_port[1].index;
  assign bus.s1_pfn    = g_port[1].lo[24:5];
  assign bus.s1_c      = g_port[1].lo[4:2];
  assign bus.s1_d      = g_port[1].lo[1];
  assign bus.s1_v      = g_port[1].lo[0];

endmodule
